// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run-control and debug clock-enable generator for the Processor core
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_op/cmd_count host command
// (0 HALT, 1 RUN, 2 STEP, 3 RUN_N); bp_en/bp_sel/bp_value breakpoint on one of the
// NUM_CH channels packed in mon_data; proc_ce core clock enable; run_state,
// cycle_cnt, halt_cause, done, cmd_err status.
module proc_run_ctrl #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 8,
  parameter int CYC_W  = 32,
  parameter int LIMIT  = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_op,
  input  logic [CYC_W-1:0]           cmd_count,
  input  logic                       bp_en,
  input  logic [$clog2(NUM_CH)-1:0]  bp_sel,
  input  logic [DATA_W-1:0]          bp_value,
  input  logic [NUM_CH*DATA_W-1:0]   mon_data,
  output logic                       proc_ce,
  output logic [1:0]                 run_state,
  output logic [CYC_W-1:0]           cycle_cnt,
  output logic [2:0]                 halt_cause,
  output logic                       done,
  output logic                       cmd_err
);
  localparam int SEL_W = $clog2(NUM_CH);
  typedef enum logic [1:0] {HALTED, RUN, STEP, RUN_N} state_t;
  state_t state;
  logic first;
  logic [CYC_W-1:0] remaining;
  logic [DATA_W-1:0] sel_data;
  logic sel_ok, halt_cmd, lim_hit, bp_hit;
  always_comb begin
    sel_data = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (bp_sel == SEL_W'(k)) begin
        sel_data = mon_data[k*DATA_W +: DATA_W];
        sel_ok = 1'b1;
      end
  end
  assign halt_cmd = cmd_valid && cmd_op == 2'd0;
  assign lim_hit = LIMIT != 0 && cycle_cnt >= CYC_W'(LIMIT);
  // first masks the breakpoint for one cycle after resume so a halted match steps over
  assign bp_hit = bp_en && !first && sel_ok && sel_data == bp_value;
  assign proc_ce = !rst && state != HALTED && !halt_cmd && !lim_hit && !bp_hit;
  assign run_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HALTED;
      cycle_cnt <= '0;
      halt_cause <= 3'd0;
      done <= 1'b0;
      cmd_err <= 1'b0;
      remaining <= '0;
      first <= 1'b0;
    end else begin
      done <= 1'b0;
      cmd_err <= state != HALTED && cmd_valid && cmd_op != 2'd0;
      if (proc_ce && ~&cycle_cnt) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == HALTED) begin
        if (cmd_valid && lim_hit) begin
          halt_cause <= 3'd5;
          done <= 1'b1;
        end else if (cmd_valid && (cmd_op == 2'd1 || cmd_op == 2'd2)) begin
          state <= cmd_op == 2'd1 ? RUN : STEP;
          first <= 1'b1;
        end else if (cmd_valid && cmd_op == 2'd3) begin
          if (cmd_count != '0) begin
            state <= RUN_N;
            remaining <= cmd_count;
            first <= 1'b1;
          end else begin
            halt_cause <= 3'd3;
            done <= 1'b1;
          end
        end
      end else begin
        first <= 1'b0;
        if (halt_cmd || lim_hit || bp_hit || state == STEP || (state == RUN_N && remaining == CYC_W'(1))) begin
          state <= HALTED;
          done <= 1'b1;
          halt_cause <= halt_cmd ? 3'd1 : lim_hit ? 3'd5 : bp_hit ? 3'd4 : state == STEP ? 3'd2 : 3'd3;
        end else if (state == RUN_N) begin
          remaining <= remaining - CYC_W'(1);
        end
      end
    end
  end
endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Synthesizable run-control and debug block for the Processor core.
- Gates the core via a clock enable and supports free-run, single-step, run-N-cycles, value breakpoints on one of NUM_CH monitored debug buses, and a global cycle budget.
- Sits between clk and the Processor instance, in simulation and on the DE0 board.
- Generalises the fixed clock and fixed cycle-limit harness into a parametrised, host-commandable controller.

Parameters:
- DATA_W, 16, width of each monitored debug channel (R0..R7, DEV_* buses).
- NUM_CH, 8, number of monitored channels (>=2).
- CYC_W, 32, width of the cycle counter and the run-N count.
- LIMIT, 50, cycle budget; the core halts after LIMIT enabled cycles since reset; 0 = unlimited.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command strobe, sampled at posedge clk
- cmd_op  in  2  command: 0 HALT, 1 RUN, 2 STEP, 3 RUN_N
- cmd_count  in  CYC_W  cycle count for RUN_N
- bp_en  in  1  breakpoint enable
- bp_sel  in  $clog2(NUM_CH)  channel compared against bp_value
- bp_value  in  DATA_W  breakpoint match value
- mon_data  in  NUM_CH*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W]
- proc_ce  out  1  clock enable to the Processor
- run_state  out  2  0 HALTED, 1 RUN, 2 STEP, 3 RUN_N
- cycle_cnt  out  CYC_W  enabled cycles since reset, saturating at all-ones
- halt_cause  out  3  0 reset, 1 host HALT, 2 step done, 3 RUN_N done, 4 breakpoint, 5 cycle limit
- done  out  1  one-cycle pulse on every entry to HALTED, except entry via reset
- cmd_err  out  1  one-cycle pulse when a non-HALT command arrives while not HALTED

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high, and takes priority over everything.
  - run_state=HALTED, cycle_cnt=0, halt_cause=0, done=0, cmd_err=0, remaining=0, first=0.
  - proc_ce=0 in the cycle rst is asserted.
- proc_ce is combinational: (run_state!=HALTED) && !halt_cmd && !lim_hit && !bp_hit.
  - halt_cmd = cmd_valid && cmd_op==0.
  - lim_hit = LIMIT!=0 && cycle_cnt>=LIMIT.
  - bp_hit = bp_en && !first && chan[bp_sel]==bp_value; bp_sel>=NUM_CH never matches.
- cycle_cnt increments on every cycle with proc_ce=1.
- HALTED:
  - RUN goes to RUN; STEP goes to STEP; both set first=1.
  - RUN_N with cmd_count>0 goes to RUN_N, loads remaining=cmd_count, sets first=1.
  - RUN_N with cmd_count=0 stays HALTED, pulses done, sets halt_cause=3, and enables no cycles.
  - HALT while HALTED is a no-op: no done pulse, halt_cause unchanged.
  - Any command is rejected when lim_hit: state stays HALTED, halt_cause=5, done pulses.
  - proc_ce first rises in the cycle after command acceptance.
- first clears after the first cycle spent in RUN, STEP or RUN_N. This gives step-over: a breakpoint already matching at resume does not re-halt.
- Running states: exit checks in priority order; the first true condition sends the block to HALTED with the listed cause and a done pulse.
  1. halt_cmd: cause 1.
  2. lim_hit: cause 5.
  3. bp_hit: cause 4.
  4. STEP after its single enabled cycle: cause 2.
  5. RUN_N when remaining==1 on an enabled cycle: cause 3.
- RUN_N decrements remaining on each enabled cycle.
- RUN continues until one of the conditions above.
- Halts caused by halt_cmd, lim_hit or bp_hit suppress proc_ce in the deciding cycle. The core therefore never executes the breakpointed or over-budget cycle.
- A non-HALT command in a running state is ignored; cmd_err pulses for one cycle and the state is unchanged.
- cycle_cnt saturates at 2^CYC_W-1 and never wraps.
- halt_cause holds its value until the next halt or reset.
- rst asserted mid-run forces the reset values at that edge, and proc_ce=0 from that cycle.

Test Plan:
- Reset values: rst high 2 cycles -> proc_ce=0, run_state=0, cycle_cnt=0, halt_cause=0, done never pulses.
- STEP: 3 STEP commands, each issued after the previous done -> exactly 3 single-cycle proc_ce pulses, cycle_cnt=3, halt_cause=2, 3 done pulses.
- RUN_N: RUN_N count=5 -> proc_ce high exactly 5 consecutive cycles starting 1 cycle after the command, halt_cause=3. RUN_N count=0 -> no proc_ce, done pulses, halt_cause=3.
- Breakpoint: bp_sel=2, bp_value=0x0007, channel 2 is a counter of enabled cycles starting at 0, then RUN -> halts with 7 enabled cycles, halt_cause=4, proc_ce low in the match cycle. Re-issue RUN -> core advances past 0x0007 (step-over).
- Cycle limit: LIMIT=50, RUN, no breakpoint -> cycle_cnt stops at 50, halt_cause=5. Further RUN -> rejected, done pulses, cycle_cnt stays 50.
- Host halt and errors: RUN, then STEP mid-run -> cmd_err pulse, state stays RUN. HALT -> proc_ce low that same cycle, halt_cause=1. rst during RUN -> all reset values next cycle.
